// File: rtl/game_pkg.sv
// Shared definitions for the maze game: direction bit positions, mover indices
// and the lookup scheduler state encoding.
package game_pkg;

    localparam int COORD_W = 10;
    localparam int PAC_IDX = 0;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        WAIT = 2'd2
    } sched_state_e;

    function automatic int step_div(input int idx, input int pac_div, input int ghost_div);
        return (idx == PAC_IDX) ? pac_div : ghost_div;
    endfunction

endpackage

// File: rtl/step_divider.sv
// Per-mover frame divider: flags a due step on every DIV-th frame tick while the
// game runs; clr restarts the count.
module step_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic due_set
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    // Wrap detection; the due flag is raised in the same edge the count wraps
    always_comb begin
        wrap_s  = (cnt_r == LAST);
        due_set = tick & ~clr & wrap_s;
    end

    // Frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            cnt_r <= wrap_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/move_step_scheduler.sv
// Game-tick scheduler: divides frame ticks into per-mover steps and arbitrates the
// movers' accesses to the shared intersection ROM, returning can-go bits and step_en.
module move_step_scheduler
    import game_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int COORD_W   = game_pkg::COORD_W,
    parameter int PAC_DIV   = 2,
    parameter int GHOST_DIV = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     run,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*COORD_W-1:0] req_x,
    input  logic [N_REQ*COORD_W-1:0] req_y,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rom_en,
    output logic [COORD_W-1:0]       rom_addr_x,
    output logic [COORD_W-1:0]       rom_addr_y,
    input  logic [3:0]               rom_data,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [3:0]               rsp_dirs,
    output logic [N_REQ-1:0]         step_en,
    output logic                     overrun
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    sched_state_e       state_r, state_s;
    logic [N_REQ-1:0]   due_r, due_s, due_set_s, clr_mask_s;
    logic [IDX_W-1:0]   idx_r, sel_idx_s;
    logic               sel_found_s, grant_s;
    logic [N_REQ-1:0]   gnt_s;
    logic               rom_en_s;
    logic [COORD_W-1:0] addr_x_s, addr_y_s;
    logic [N_REQ-1:0]   rsp_valid_r, step_en_r;
    logic [3:0]         rsp_dirs_r;
    logic               overrun_r;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_div
            step_divider #(
                .DIV(step_div(gi, PAC_DIV, GHOST_DIV))
            ) u_div (
                .clk    (clk),
                .reset  (reset),
                .clr    (~run),
                .tick   (frame_tick),
                .due_set(due_set_s[gi])
            );
        end
    endgenerate

    // Fixed-priority pick of the lowest due mover (pacman wins)
    always_comb begin
        sel_idx_s   = {IDX_W{1'b0}};
        sel_found_s = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sel_idx_s   = due_r[i] ? IDX_W'(i) : sel_idx_s;
            sel_found_s = sel_found_s | due_r[i];
        end
    end

    // Next state, grant/ROM drive and due-clear mask
    always_comb begin
        state_s    = state_r;
        gnt_s      = {N_REQ{1'b0}};
        rom_en_s   = 1'b0;
        addr_x_s   = {COORD_W{1'b0}};
        addr_y_s   = {COORD_W{1'b0}};
        clr_mask_s = {N_REQ{1'b0}};
        grant_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if ((due_r | due_set_s) != {N_REQ{1'b0}}) begin
                    state_s = ARB;
                end else begin
                    state_s = IDLE;
                end
            end
            ARB: begin
                if (sel_found_s && req[sel_idx_s]) begin
                    gnt_s    = ONE_HOT0 << sel_idx_s;
                    rom_en_s = 1'b1;
                    addr_x_s = req_x[sel_idx_s*COORD_W +: COORD_W];
                    addr_y_s = req_y[sel_idx_s*COORD_W +: COORD_W];
                    grant_s  = 1'b1;
                    state_s  = WAIT;
                end else if (sel_found_s) begin
                    // Mover not asking this step: drop its due bit and retry arbitration
                    clr_mask_s = ONE_HOT0 << sel_idx_s;
                    state_s    = ARB;
                end else if (due_set_s != {N_REQ{1'b0}}) begin
                    state_s = ARB;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                clr_mask_s = ONE_HOT0 << idx_r;
                if (((due_r & ~clr_mask_s) | due_set_s) != {N_REQ{1'b0}}) begin
                    state_s = ARB;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // A fresh due arriving on a still-pending bit merges into it
        due_s = (due_r | due_set_s) & ~clr_mask_s;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else if (!run) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Due mask, granted index, responses and overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            due_r       <= {N_REQ{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            rsp_valid_r <= {N_REQ{1'b0}};
            step_en_r   <= {N_REQ{1'b0}};
            rsp_dirs_r  <= 4'd0;
            overrun_r   <= 1'b0;
        end else if (!run) begin
            due_r       <= {N_REQ{1'b0}};
            idx_r       <= idx_r;
            rsp_valid_r <= {N_REQ{1'b0}};
            step_en_r   <= {N_REQ{1'b0}};
            rsp_dirs_r  <= rsp_dirs_r;
            overrun_r   <= 1'b0;
        end else begin
            due_r     <= due_s;
            idx_r     <= grant_s ? sel_idx_s : idx_r;
            overrun_r <= |(due_r & due_set_s);
            if (state_r == WAIT) begin
                rsp_valid_r <= ONE_HOT0 << idx_r;
                step_en_r   <= ONE_HOT0 << idx_r;
                rsp_dirs_r  <= rom_data;
            end else begin
                rsp_valid_r <= {N_REQ{1'b0}};
                step_en_r   <= {N_REQ{1'b0}};
                rsp_dirs_r  <= rsp_dirs_r;
            end
        end
    end

    assign gnt        = gnt_s;
    assign rom_en     = rom_en_s;
    assign rom_addr_x = addr_x_s;
    assign rom_addr_y = addr_y_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_dirs   = rsp_dirs_r;
    assign step_en    = step_en_r;
    assign overrun    = overrun_r;

endmodule
